// File: rtl/bx0_sync_monitor.sv
// rtl/bx0_sync_monitor.sv - local BXN counter with TTC BX0 sync check and ALCT bx0 match check
//
// Optional feature macro: BX0_ERR_CNT_EN
//   defined   : saturating sync/match error counters are built, cleared by cnt_reset
//   undefined : both error counts read 0 and cnt_reset has no effect
//
// The BXN counter free-runs once locked by the first TTC BX0; later BX0s are only
// checked against bxn_offset, never used to re-align the counter.

module bx0_sync_monitor #(
  parameter int MXBXN     = 12,
  parameter int LHC_CYCLE = 3564,
  parameter int MXCNT     = 8
) (
  input  logic             clock,
  input  logic             global_reset,
  input  logic             ttc_resync,
  input  logic             ttc_bx0,
  input  logic [MXBXN-1:0] bxn_offset,
  input  logic             alct_bx0,
  input  logic             alct_bx0_en,
  input  logic [3:0]       alct_bx0_delay,
  input  logic             cnt_reset,
  output logic [MXBXN-1:0] bxn_counter,
  output logic             bxn_run,
  output logic             clct_bx0,
  output logic             clct_bx0_sync_err,
  output logic             bx0_match_err,
  output logic [MXCNT-1:0] bx0_sync_err_cnt,
  output logic [MXCNT-1:0] bx0_match_err_cnt
);

  // Last legal BXN value and the cycle length widened by one bit so that
  // offset+1 can be compared without overflow.
  localparam logic [MXBXN-1:0] BXN_LAST  = MXBXN'(LHC_CYCLE - 1);
  localparam logic [MXBXN:0]   LHC_WIDE  = (MXBXN+1)'(LHC_CYCLE);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [MXBXN:0]   offset_p1;
  logic [MXBXN:0]   offset_p1_wrapped;
  logic [MXBXN-1:0] bxn_load;
  logic [MXBXN-1:0] bxn_inc;
  logic             offset_valid;
  logic             sync_check;
  logic             sync_bad;
  logic [15:0]      dly_sr;
  logic             clct_bx0_dly;
  logic             match_nxt;
  logic             match_set;

  // State register: resync/BX0 sequencing of the local counter
  always_ff @(posedge clock) begin
    if (global_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: resync always returns to IDLE, even against a coincident BX0
  always_comb begin
    state_nxt = state;
    if (ttc_resync) begin
      state_nxt = IDLE;
    end else if ((state == IDLE) && ttc_bx0) begin
      state_nxt = RUN;
    end
  end

  // Output decode from registered state and counter
  always_comb begin
    bxn_run  = (state == RUN);
    clct_bx0 = (state == RUN) && (bxn_counter == '0);
  end

  // Counter arithmetic: offset+1 folded back into the LHC cycle, and run-time
  // increment with wrap. A single subtraction covers every offset the port can
  // carry as long as 2^MXBXN < 2*LHC_CYCLE, which holds for the default sizing.
  always_comb begin
    offset_p1         = {1'b0, bxn_offset} + (MXBXN+1)'(1);
    offset_p1_wrapped = (offset_p1 >= LHC_WIDE) ? (offset_p1 - LHC_WIDE) : offset_p1;
    bxn_load          = offset_p1_wrapped[MXBXN-1:0];
    bxn_inc           = (bxn_counter >= BXN_LAST) ? '0 : (bxn_counter + MXBXN'(1));
  end

  // Local BXN counter: parks on the offset in IDLE, free-runs in RUN
  always_ff @(posedge clock) begin
    if (global_reset) begin
      bxn_counter <= '0;
    end else if (ttc_resync) begin
      bxn_counter <= bxn_offset;
    end else if (state == IDLE) begin
      bxn_counter <= ttc_bx0 ? bxn_load : bxn_offset;
    end else begin
      bxn_counter <= bxn_inc;
    end
  end

  // Sync comparison: an out-of-cycle offset can never be reached by the
  // running counter, so it is treated as a guaranteed mismatch.
  always_comb begin
    offset_valid = ({1'b0, bxn_offset} < LHC_WIDE);
    sync_check   = (state == RUN) && ttc_bx0;
    sync_bad     = sync_check && !(offset_valid && (bxn_counter == bxn_offset));
  end

  // Sync error level: updated only at BX0 arrivals in RUN, survives resync
  always_ff @(posedge clock) begin
    if (global_reset) begin
      clct_bx0_sync_err <= 1'b0;
    end else if (sync_check) begin
      clct_bx0_sync_err <= sync_bad;
    end
  end

  // clct_bx0 history used to line the local marker up with the ALCT round trip
  always_ff @(posedge clock) begin
    if (global_reset || ttc_resync) begin
      dly_sr <= '0;
    end else begin
      dly_sr <= {dly_sr[14:0], clct_bx0};
    end
  end

  // Tap selection: delay 0 bypasses the shift register entirely
  always_comb begin
    clct_bx0_dly = (alct_bx0_delay == 4'd0) ? clct_bx0 : dly_sr[alct_bx0_delay - 4'd1];
    match_nxt    = alct_bx0_en && (state == RUN) && (clct_bx0_dly != alct_bx0);
    match_set    = match_nxt && !ttc_resync;
  end

  // Match error pulse: one clock per mismatched cycle, killed by resync
  always_ff @(posedge clock) begin
    if (global_reset || ttc_resync) begin
      bx0_match_err <= 1'b0;
    end else begin
      bx0_match_err <= match_nxt;
    end
  end

`ifdef BX0_ERR_CNT_EN

  // Saturating sync error count; the VME clear beats a coincident increment
  always_ff @(posedge clock) begin
    if (global_reset || cnt_reset) begin
      bx0_sync_err_cnt <= '0;
    end else if (sync_bad && (bx0_sync_err_cnt != '1)) begin
      bx0_sync_err_cnt <= bx0_sync_err_cnt + MXCNT'(1);
    end
  end

  // Saturating match error count, advanced on the same edge that raises the pulse
  always_ff @(posedge clock) begin
    if (global_reset || cnt_reset) begin
      bx0_match_err_cnt <= '0;
    end else if (match_set && (bx0_match_err_cnt != '1)) begin
      bx0_match_err_cnt <= bx0_match_err_cnt + MXCNT'(1);
    end
  end

`else

  logic unused_cnt_inputs;

  // Counters absent: readout is constant zero
  always_comb begin
    bx0_sync_err_cnt  = '0;
    bx0_match_err_cnt = '0;
    unused_cnt_inputs = cnt_reset ^ match_set;
  end

`endif

endmodule

// File: doc/bx0_sync_monitor.md
# bx0_sync_monitor

Upstream source of the bunch-crossing sync error signals consumed by the sync error controller. Runs the local 12-bit BXN counter and checks it against TTC BX0 arrivals, producing `clct_bx0_sync_err` (level). Also emits the local `clct_bx0` marker and compares a delayed copy against the ALCT-returned `alct_bx0`, producing `bx0_match_err` (1-clock pulse). Keeps saturating error counts for VME readout.

## Interface
- `MXBXN`, default 12: BXN counter width.
- `LHC_CYCLE`, default 3564: BXN counter modulus. Count runs 0..`LHC_CYCLE`-1.
- `MXCNT`, default 8: error counter width.
- `clock`, in, 1: main 40 MHz clock. The block uses this single clock.
- `global_reset`, in, 1: reset, synchronous, active-high. Dominates all other inputs.
- `ttc_resync`, in, 1: TTC resync command.
- `ttc_bx0`, in, 1: TTC BX0 pulse.
- `bxn_offset`, in, `MXBXN`: expected BXN value at `ttc_bx0` arrival.
- `alct_bx0`, in, 1: BX0 marker returned from ALCT.
- `alct_bx0_en`, in, 1: enables the ALCT/CLCT bx0 comparison.
- `alct_bx0_delay`, in, 4: delay applied to `clct_bx0` before comparison, 0..15 clocks.
- `cnt_reset`, in, 1: VME clear of the error counters.
- `bxn_counter`, out, `MXBXN`: local BXN.
- `bxn_run`, out, 1: counter is running (state RUN).
- `clct_bx0`, out, 1: local BX0 marker.
- `clct_bx0_sync_err`, out, 1: BXN did not equal `bxn_offset` at the last `ttc_bx0`.
- `bx0_match_err`, out, 1: delayed `clct_bx0` differs from `alct_bx0`.
- `bx0_sync_err_cnt`, out, `MXCNT`: saturating count of `clct_bx0_sync_err` events.
- `bx0_match_err_cnt`, out, `MXCNT`: saturating count of `bx0_match_err` pulses.

## Operation
- **Reset values.** On `global_reset`, every output is 0, the state is IDLE, and `bxn_counter` is 0.
- **FSM IDLE.**
  - `bxn_counter` holds `bxn_offset`.
  - `ttc_bx0` loads `bxn_offset`+1 (mod `LHC_CYCLE`) and moves to RUN.
- **FSM RUN.**
  - `bxn_counter` increments each clock, wrapping from `LHC_CYCLE`-1 to 0.
  - The counter is never corrected by `ttc_bx0`; it only flags mismatches.
- **ttc_resync.**
  - Returns to IDLE and clears the delay line and `bx0_match_err`.
  - Does NOT clear `clct_bx0_sync_err` or the counters.
  - If asserted together with `ttc_bx0`, resync wins and the state stays IDLE.
- **Sync check.** At each `ttc_bx0` in RUN:
  - `clct_bx0_sync_err` is set if `bxn_counter` ≠ `bxn_offset`, and cleared if they are equal.
  - A set increments `bx0_sync_err_cnt`.
  - The output holds between BX0s; only a matching BX0 or `global_reset` clears it.
  - `bxn_offset` ≥ `LHC_CYCLE` never matches, so every BX0 flags an error.
- **clct_bx0.** `clct_bx0` = (RUN && `bxn_counter`==0), decoded from registered state.
- **Match check.**
  - `clct_bx0` enters a 16-stage shift register; the tap selected by `alct_bx0_delay` gives `clct_bx0_dly` (delay 0 means undelayed).
  - When `alct_bx0_en` && RUN: `bx0_match_err` <= (`clct_bx0_dly` ≠ `alct_bx0`).
  - Otherwise `bx0_match_err` is 0.
  - Each pulse increments `bx0_match_err_cnt`.
- **Counters.**
  - Counters saturate at 2^`MXCNT`-1.
  - `cnt_reset` zeroes both counters and wins over a simultaneous increment.

## Timing
- `bxn_counter`: `ttc_bx0` in IDLE at clock N gives `bxn_offset`+1 at N+1.
- `clct_bx0_sync_err` and the counter increment: register one clock after the `ttc_bx0` clock.
- `clct_bx0_dly`: lags `clct_bx0` by exactly `alct_bx0_delay` clocks.
- `bx0_match_err`: registered, one clock after the compared cycle; width 1 clock per mismatched cycle.
- Changing `alct_bx0_delay` mid-run may cause one spurious mismatch; this is accepted behaviour.

## Configuration
- **Macro:** `BX0_ERR_CNT_EN`.
- **Defined:** both saturating error counters are built as described.
- **Undefined:**
  - `bx0_sync_err_cnt` and `bx0_match_err_cnt` are tied to 0.
  - `cnt_reset` is ignored.
  - All other behaviour is identical.

## Test plan
- **Lock and count:** `bxn_offset`=5, first `ttc_bx0` at clock 10, then `ttc_bx0` every 3564 clocks → `bxn_counter`=6 at clock 11, wrap 3563→0, `clct_bx0_sync_err` stays 0, counts 0.
- **Sync error latch and clear:** shift one `ttc_bx0` early by 1 clock → `clct_bx0_sync_err`=1 one clock later, `bx0_sync_err_cnt`=1. A `ttc_resync` keeps it at 1. The next correctly timed BX0 clears it.
- **Match delay:** `alct_bx0_en`=1, `alct_bx0_delay`=3, `alct_bx0` driven 3 clocks after `clct_bx0` → no `bx0_match_err`. Driven 4 clocks after → two 1-clock pulses, count=2.
- **Resync priority:** `ttc_resync` and `ttc_bx0` in the same clock while in RUN → state IDLE, `bxn_counter`=`bxn_offset`, `bx0_match_err`=0.
- **Saturation and clear:** force 300 sync errors with `MXCNT`=8 → count holds 255. `cnt_reset` together with an error → count 0.
- **Reset mid-run:** `global_reset` during an error burst → all outputs 0 next clock and state IDLE. With the macro undefined, both counts stay 0 throughout.
